sram_ctrl_async: RTL
====================

Name: sram_ctrl_async

Overview:
- Parametrised asynchronous-SRAM controller. Next generation of the Nexys2 8-bit SRAM test controller.
- Generalises data width (8/16 bits with byte lanes), address width and read/write wait states.
- Adds a req/ack host handshake, a write-hold phase and a read-to-write bus turnaround.
- Sits between the system bus master and the board SRAM pins. The board top owns the bus transceiver enables.

Parameters:
- DATA_W, 8, SRAM data width; legal values 8 or 16. Local BE_W = DATA_W/8.
- ADDR_W, 19, SRAM word-address width.
- WAIT_RD, 2, extra read cycles; oe_n is held low for WAIT_RD+1 cycles.
- WAIT_WR, 2, extra write cycles; we_n is held low for WAIT_WR+1 cycles.
- TURNAROUND, 1, idle cycles with the bus released after every read; legal range 0..7.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  host request; sampled only when busy=0.
- we  in  1  1 = write, 0 = read; captured with req.
- adr  in  ADDR_W  word address; captured with req.
- wdat  in  DATA_W  write data; captured with req.
- be  in  BE_W  byte enables, active high; captured with req.
- ack  out  1  one-cycle completion pulse.
- rdat  out  DATA_W  read data; valid when ack=1 for a read, held until the next read.
- busy  out  1  high in every state except IDLE.
- sram_adr  out  ADDR_W  SRAM address.
- sram_dat  inout  DATA_W  SRAM data bus; tri-stated unless writing.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_ub_n  out  1  upper byte enable, active low.
- sram_lb_n  out  1  lower byte enable, active low.

Behaviour:
- Reset (asynchronous, also mid-operation):
  - state = IDLE.
  - ce_n, we_n, oe_n, ub_n, lb_n all 1; sram_dat = Z.
  - sram_adr = 0, rdat = 0, ack = 0, busy = 0.
  - Any in-flight access is abandoned and produces no ack.
- All SRAM control outputs are registered. No combinational path from host inputs to pins.
- Acceptance: at a rising edge with state = IDLE and req = 1, the controller registers adr/we/wdat/be and drives sram_adr. req while busy = 1 is ignored (not queued).
- States: IDLE, RD, WR, WHOLD, TURN.
- IDLE:
  - ce_n = 1, we_n = 1, oe_n = 1, bus Z.
  - Next state is RD if req & ~we, WR if req & we.
- RD:
  - ce_n = 0, oe_n = 0, ub_n/lb_n from be, bus Z.
  - Wait counter runs 0..WAIT_RD. At the edge ending the last RD cycle, sram_dat is sampled into rdat.
  - Next state is TURN if TURNAROUND > 0, else IDLE.
  - ack is high in the cycle after the last RD cycle.
- TURN:
  - ce_n = 1, oe_n = 1, bus Z, busy = 1.
  - Lasts TURNAROUND cycles, then IDLE.
- WR:
  - ce_n = 0, we_n = 0, oe_n = 1, sram_dat driven with the captured wdat from the first WR cycle.
  - Lasts WAIT_WR+1 cycles, then WHOLD.
- WHOLD:
  - 1 cycle; we_n = 1, ce_n = 0, data and address still driven (hold time).
  - ack = 1 in this cycle; next state IDLE.
- Latency from the accepting edge to ack high:
  - read: WAIT_RD+2 edges (defaults: 4).
  - write: WAIT_WR+2 edges (defaults: 4).
- Back-to-back:
  - After a write, a new req can be accepted at the edge leaving WHOLD+1 (IDLE cycle).
  - After a read, req is accepted only after TURN.
  - Minimum IDLE gap between accesses is 1 cycle.
- Byte lanes:
  - DATA_W = 16: ub_n = ~be[1], lb_n = ~be[0].
  - DATA_W = 8: ub_n = lb_n = ~be[0].
  - be = 0 still performs the cycle with both lanes disabled.
- Invariants:
  - sram_dat is never driven while oe_n = 0.
  - we_n and oe_n are never both 0.
  - sram_adr is stable from the first to the last cycle of ce_n = 0.
  - ack is never high for 2 consecutive cycles.

Test Plan:
- Reset mid-write: assert reset_n = 0 during WR -> same cycle we_n = 1, ce_n = 1, bus Z, no ack; after release, busy = 0.
- Write, defaults, DATA_W = 16: req, we = 1, adr = 19'h1234, wdat = 16'hA55A, be = 2'b11 -> we_n low for 3 cycles, WHOLD with dat still A55A, ack at edge +4, ub_n = lb_n = 0.
- Read, defaults: SRAM model returns 16'hF00F when oe_n = 0; req, we = 0, adr = 19'h1234 -> oe_n low for 3 cycles, ack at edge +4, rdat = F00F, then TURN for 1 cycle with bus Z.
- Read then write with req held high: second access is accepted only after TURN. Check via a monitor that dat is never driven while oe_n = 0.
- DATA_W = 8, WAIT_RD = 0, WAIT_WR = 0, TURNAROUND = 0: write 8'hAA then read -> write ack at edge +2, read ack at edge +2, rdat = AA.
- Byte lane: be = 2'b10 -> ub_n = 0, lb_n = 1 during the write. req pulsed while busy -> ignored, exactly one ack.

Source files
------------

// File: rtl/sram_ctrl_async.sv
// rtl/sram_ctrl_async.sv - asynchronous SRAM controller with req/ack host handshake
// All pin-side outputs are registered; pin values are computed from the next state.
module sram_ctrl_async #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int WAIT_RD    = 2,
  parameter int WAIT_WR    = 2,
  parameter int TURNAROUND = 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdat,
  input  logic [BE_W-1:0]   be,
  output logic              ack,
  output logic [DATA_W-1:0] rdat,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_adr,
  inout  wire  [DATA_W-1:0] sram_dat,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CNT_MAX = (WAIT_RD > WAIT_WR) ?
                           ((WAIT_RD > TURNAROUND) ? WAIT_RD : TURNAROUND) :
                           ((WAIT_WR > TURNAROUND) ? WAIT_WR : TURNAROUND);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(WAIT_RD);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WAIT_WR);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WHOLD,
    S_TURN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                ack_q, ack_d;
  logic                dat_oe_q, dat_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic [1:0]          host_lane_n;
  logic [1:0]          lane_src_n;

  // An 8-bit part has a single lane, so both strobes follow be[0].
  assign host_lane_n = {~be[BE_W-1], ~be[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      dat_oe_q <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      dat_oe_q <= dat_oe_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    ack_d      = 1'b0;
    dat_oe_d   = 1'b0;
    ce_n_d     = 1'b1;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    ub_n_d     = 1'b1;
    lb_n_d     = 1'b1;
    lane_src_n = (state_q == S_IDLE) ? host_lane_n : {ub_n_q, lb_n_q};

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d   = adr;
          wdat_d  = wdat;
          cnt_d   = '0;
          state_d = we ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          rdat_d  = sram_dat;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = (TURNAROUND > 0) ? S_TURN : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR: begin
        if (cnt_q == WR_LAST) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WHOLD: begin
        state_d = S_IDLE;
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // WHOLD keeps address, data and lanes driven with we_n already high.
    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        {ub_n_d, lb_n_d} = lane_src_n;
      end
      S_WR: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        dat_oe_d = 1'b1;
        {ub_n_d, lb_n_d} = lane_src_n;
      end
      S_WHOLD: begin
        ce_n_d   = 1'b0;
        dat_oe_d = 1'b1;
        {ub_n_d, lb_n_d} = lane_src_n;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  assign sram_dat  = dat_oe_q ? wdat_q : {DATA_W{1'bz}};
  assign sram_adr  = adr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign rdat      = rdat_q;
  assign ack       = ack_q;
  assign busy      = (state_q != S_IDLE);

endmodule
